// File: rtl/array_index_walker_pkg.sv
// Shared types and elaboration-time helpers for the array index walker.
// Holds the dimension descriptor, its size/step helpers and the walk state encoding.
package array_walk_pkg;

  typedef struct packed {
    int l;
    int r;
  } dim_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } walk_state_t;

  function automatic int unsigned dim_size(dim_t d);
    int diff;
    diff = d.r - d.l;
    if (diff < 0) diff = -diff;
    return int'(diff + 1);
  endfunction

  function automatic int dim_step(dim_t d);
    return (d.l <= d.r) ? 1 : -1;
  endfunction

endpackage

// File: rtl/array_index_walker_dim_counter.sv
// One dimension of the walker: steps from the left bound toward the right bound,
// wraps to the left bound on a carried step and propagates the carry outward.
module array_dim_counter
  import array_walk_pkg::*;
#(
  parameter dim_t        DIM   = '{l: 0, r: 0},
  parameter int unsigned IDX_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    advance,
  input  logic                    carry_in,
  output logic signed [IDX_W-1:0] idx,
  output logic                    at_right,
  output logic                    carry_out
);

  localparam logic signed [IDX_W-1:0] LEFT  = IDX_W'(DIM.l);
  localparam logic signed [IDX_W-1:0] RIGHT = IDX_W'(DIM.r);
  localparam logic signed [IDX_W-1:0] STEP  = IDX_W'(dim_step(DIM));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= LEFT;
    end else if (advance && carry_in) begin
      idx <= at_right ? LEFT : idx + STEP;
    end
  end

  assign at_right  = (idx == RIGHT);
  assign carry_out = carry_in & at_right;

endmodule

// File: rtl/array_index_walker.sv
// Walks every element of a 4-D array in declaration order (dim 1 slowest) over valid/ready.
// Optional macro ARRAY_INDEX_WALKER_FLAT_EN adds the linear ordinal output 'flat'.
module array_index_walker
  import array_walk_pkg::*;
#(
  parameter int          L1    = 1,
  parameter int          R1    = 5,
  parameter int          L2    = 2,
  parameter int          R2    = 8,
  parameter int          L3    = 3,
  parameter int          R3    = 0,
  parameter int          L4    = 2,
  parameter int          R4    = 1,
  parameter int unsigned IDX_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [IDX_W-1:0] idx1,
  output logic signed [IDX_W-1:0] idx2,
  output logic signed [IDX_W-1:0] idx3,
  output logic signed [IDX_W-1:0] idx4,
  output logic                    last,
  output logic                    busy,
  output logic                    done
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
  ,
  output logic [31:0]             flat
`endif
);

  localparam dim_t D1 = '{l: L1, r: R1};
  localparam dim_t D2 = '{l: L2, r: R2};
  localparam dim_t D3 = '{l: L3, r: R3};
  localparam dim_t D4 = '{l: L4, r: R4};

  walk_state_t state, state_n;
  logic        load, adv;
  logic [4:1]  ar;
  logic [4:1]  cy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // cy[1] means every dimension sits on its right bound: the final tuple.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          if (cy[1]) state_n = DONE;
          else       adv     = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign out_valid = (state == RUN);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign last      = (state == RUN) && (&ar);

  array_dim_counter #(.DIM(D4), .IDX_W(IDX_W)) u_dim4 (
    .clk(clk), .rst(rst), .load(load), .advance(adv), .carry_in(1'b1),
    .idx(idx4), .at_right(ar[4]), .carry_out(cy[4])
  );

  array_dim_counter #(.DIM(D3), .IDX_W(IDX_W)) u_dim3 (
    .clk(clk), .rst(rst), .load(load), .advance(adv), .carry_in(cy[4]),
    .idx(idx3), .at_right(ar[3]), .carry_out(cy[3])
  );

  array_dim_counter #(.DIM(D2), .IDX_W(IDX_W)) u_dim2 (
    .clk(clk), .rst(rst), .load(load), .advance(adv), .carry_in(cy[3]),
    .idx(idx2), .at_right(ar[2]), .carry_out(cy[2])
  );

  array_dim_counter #(.DIM(D1), .IDX_W(IDX_W)) u_dim1 (
    .clk(clk), .rst(rst), .load(load), .advance(adv), .carry_in(cy[2]),
    .idx(idx1), .at_right(ar[1]), .carry_out(cy[1])
  );

`ifdef ARRAY_INDEX_WALKER_FLAT_EN
  localparam int unsigned TOTAL = dim_size(D1) * dim_size(D2) * dim_size(D3) * dim_size(D4);

  // The ordinal holds at TOTAL-1 through DONE, like the indices hold at the R bounds.
  always_ff @(posedge clk) begin
    if (rst)       flat <= '0;
    else if (load) flat <= '0;
    else if (adv)  flat <= flat + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst && last) assert (flat == 32'(TOTAL - 1));
  end
`endif

endmodule

// File: tb/tb_array_index_walker.sv
// Scoreboard bench for array_index_walker: default 4-D walk plus a single-element instance.
module tb_array_index_walker;

  localparam int W = 32;

  typedef struct {
    int   ord;
    int   i1, i2, i3, i4;
    logic lst;
  } exp_t;

  typedef struct {
    int ord;
    int i1, i2, i3, i4;
  } dir_t;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic out_valid, last, busy, done;
  logic signed [W-1:0] idx1, idx2, idx3, idx4;
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
  logic [31:0] flat;
  logic [31:0] flat1;
`endif

  logic start1;
  logic valid1, last1, busy1, done1;
  logic signed [W-1:0] j1, j2, j3, j4;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int busy_cyc = 0;
  int done_cnt = 0;
  int one_tuples = 0;
  int one_busy = 0;
  int one_done = 0;
  exp_t q[$];

  // Hand-computed tuples for the default bounds (1..5, 2..8, 3..0, 2..1).
  dir_t dirs[6] = '{
    '{0,   1, 2, 3, 2},
    '{1,   1, 2, 3, 1},
    '{2,   1, 2, 2, 2},
    '{8,   1, 3, 3, 2},
    '{56,  2, 2, 3, 2},
    '{279, 5, 8, 0, 1}
  };

  always #5 clk = ~clk;

  array_index_walker #(
    .L1(1), .R1(5), .L2(2), .R2(8), .L3(3), .R3(0), .L4(2), .R4(1), .IDX_W(W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .idx1(idx1), .idx2(idx2), .idx3(idx3), .idx4(idx4),
    .last(last), .busy(busy), .done(done)
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
    , .flat(flat)
`endif
  );

  array_index_walker #(
    .L1(-3), .R1(-3), .L2(-3), .R2(-3), .L3(-3), .R3(-3), .L4(-3), .R4(-3), .IDX_W(W)
  ) u_one (
    .clk(clk), .rst(rst), .start(start1), .out_valid(valid1), .out_ready(1'b1),
    .idx1(j1), .idx2(j2), .idx3(j3), .idx4(j4),
    .last(last1), .busy(busy1), .done(done1)
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
    , .flat(flat1)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tuple(input string name, input int ord,
                             input longint a1, input longint a2, input longint a3, input longint a4,
                             input int e1, input int e2, input int e3, input int e4);
    checks++;
    if (a1 != e1 || a2 != e2 || a3 != e3 || a4 != e4) begin
      errors++;
      $display("FAIL %s ord %0d: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)",
               name, ord, a1, a2, a3, a4, e1, e2, e3, e4);
    end
  endtask

  // Declaration-order expansion: dim sizes 5,7,4,2 with steps +1,+1,-1,-1.
  task automatic push_walk();
    int n;
    exp_t e;
    n = 0;
    for (int a = 0; a < 5; a++)
      for (int b = 0; b < 7; b++)
        for (int c = 0; c < 4; c++)
          for (int d = 0; d < 2; d++) begin
            e.ord = n;
            e.i1  = 1 + a;
            e.i2  = 2 + b;
            e.i3  = 3 - c;
            e.i4  = 2 - d;
            e.lst = (n == 279);
            q.push_back(e);
            n++;
          end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cyc++;
    if (done) done_cnt++;
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_tuple", 1, 0);
      end else begin
        e = q[0];
        check_tuple("tuple", e.ord, idx1, idx2, idx3, idx4, e.i1, e.i2, e.i3, e.i4);
        check("last", last, e.lst);
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
        check("flat", flat, e.ord);
`endif
        foreach (dirs[k])
          if (dirs[k].ord == e.ord)
            check_tuple("directed", e.ord, idx1, idx2, idx3, idx4,
                        dirs[k].i1, dirs[k].i2, dirs[k].i3, dirs[k].i4);
        if (out_ready) begin
          void'(q.pop_front());
          hs_count++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy1) one_busy++;
    if (done1) one_done++;
    if (valid1) begin
      one_tuples++;
      check_tuple("one_tuple", 0, j1, j2, j3, j4, -3, -3, -3, -3);
      check("one_last", last1, 1);
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
      check("one_flat", flat1, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (hs_count >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy && !busy1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_last"}, last, 0);
    check_tuple({tag, "_idx"}, -1, idx1, idx2, idx3, idx4, 0, 0, 0, 0);
`ifdef ARRAY_INDEX_WALKER_FLAT_EN
    check({tag, "_flat"}, flat, 0);
`endif
  endtask

  initial begin
    bit ok;
    int b0, d0, h0;
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check_zero("reset");

    // Clean walk: 280 RUN cycles plus one DONE cycle are busy.
    b0 = busy_cyc; d0 = done_cnt;
    push_walk();
    pulse_start();
    wait_idle(ok);
    check("walk1_finished", ok, 1);
    check("walk1_busy_cycles", busy_cyc - b0, 281);
    check("walk1_done_pulses", done_cnt - d0, 1);
    check("walk1_queue_empty", q.size(), 0);
    check_tuple("walk1_hold", -1, idx1, idx2, idx3, idx4, 5, 8, 0, 1);

    // Backpressure at ordinal 10, stray start at 50 and during DONE.
    b0 = busy_cyc; d0 = done_cnt; h0 = hs_count;
    push_walk();
    pulse_start();
    wait_hs(h0 + 10, ok);
    check("walk2_reach10", ok, 1);
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_hs(h0 + 50, ok);
    check("walk2_reach50", ok, 1);
    pulse_start();
    wait_done(ok);
    check("walk2_reach_done", ok, 1);
    pulse_start();
    check("walk2_start_in_done_ignored", busy, 0);
    wait_idle(ok);
    check("walk2_finished", ok, 1);
    check("walk2_busy_cycles", busy_cyc - b0, 284);
    check("walk2_done_pulses", done_cnt - d0, 1);
    check("walk2_queue_empty", q.size(), 0);

    // Reset mid-walk at ordinal 100.
    d0 = done_cnt; h0 = hs_count;
    push_walk();
    pulse_start();
    wait_hs(h0 + 100, ok);
    check("walk3_reach100", ok, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    check_zero("midreset");
    repeat (4) tick();
    check("midreset_no_done", done_cnt - d0, 0);
    check("midreset_idle", busy, 0);

    // Restart after the abort.
    b0 = busy_cyc; d0 = done_cnt;
    push_walk();
    pulse_start();
    wait_idle(ok);
    check("walk4_finished", ok, 1);
    check("walk4_busy_cycles", busy_cyc - b0, 281);
    check("walk4_done_pulses", done_cnt - d0, 1);
    check("walk4_queue_empty", q.size(), 0);

    // Single-element instance: one tuple, then DONE.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    wait_idle(ok);
    check("one_finished", ok, 1);
    check("one_tuple_count", one_tuples, 1);
    check("one_busy_cycles", one_busy, 2);
    check("one_done_pulses", one_done, 1);

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
